// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - mode encodings and JK input codes for the JK register bank
package jk_pkg;

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DOWN = 2'b11;

  // Codes are the concatenation {j, k}.
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    CLR  = 2'b01,
    SET  = 2'b10,
    TOG  = 2'b11
  } jk_code_t;

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with clock enable and async reset to a fixed value
module jk_cell
  import jk_pkg::*;
#(
  parameter bit INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= INIT;
    end else if (ce) begin
      case (jk_code_t'({j, k}))
        HOLD:    q <= q;
        SET:     q <= 1'b1;
        CLR:     q <= 1'b0;
        TOG:     q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_reg_bank.sv
// rtl/jk_reg_bank.sv - bank of JK cells with JK, load, up-count and down-count modes
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter logic [31:0] INIT_VAL = 32'd0,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             changed
);

  localparam logic [WIDTH-1:0] INIT_Q = INIT_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] up_t, dn_t, jv, kv, nxt;
  logic             at_limit;

  // Toggle enables: bit i flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    logic [WIDTH-1:0] low;
    low  = '0;
    up_t = '0;
    dn_t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      low     = WIDTH'((64'd1 << i) - 64'd1);
      up_t[i] = (q & low) == low;
      dn_t[i] = (q & low) == '0;
    end
  end

  assign at_limit = ((mode == MODE_UP) && (&q)) || ((mode == MODE_DOWN) && !(|q));

  always_comb begin
    jv = '0;
    kv = '0;
    case (mode)
      MODE_JK:   begin jv = j;    kv = k;    end
      MODE_LOAD: begin jv = d;    kv = ~d;   end
      MODE_UP:   begin jv = up_t; kv = up_t; end
      default:   begin jv = dn_t; kv = dn_t; end
    endcase
    if (SATURATE && at_limit) begin
      jv = '0;
      kv = '0;
    end
  end

  // Next state as the cells will compute it; only used for the changed flag.
  assign nxt = (jv & ~q) | (~kv & q);

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell #(.INIT(INIT_Q[g])) u_cell (
      .clk  (clk),
      .reset(reset),
      .ce   (en),
      .j    (jv[g]),
      .k    (kv[g]),
      .q    (q[g])
    );
  end

  assign qn = ~q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tc      <= 1'b0;
      changed <= 1'b0;
    end else begin
      tc      <= en && at_limit;
      changed <= en && (nxt != q);
    end
  end

endmodule

// File: tb/tb_jk_reg_bank.sv
// tb/tb_jk_reg_bank.sv - scoreboard bench for jk_reg_bank in wrap, saturate and 1-bit builds
module tb_jk_reg_bank;

  localparam logic [1:0] M_JK = 2'b00, M_LD = 2'b01, M_UP = 2'b10, M_DN = 2'b11;

  logic clk = 1'b0;
  logic reset, en;
  logic [1:0] mode;
  logic [3:0] j, k, d;
  logic [3:0] q_a, qn_a, q_b, qn_b;
  logic       q_c, qn_c;
  logic       tc_a, tc_b, tc_c, changed_a, changed_b, changed_c;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         inst;
    logic [3:0] q;
    logic       tc;
    logic       ch;
  } sb_t;
  sb_t sb[$];

  logic [3:0] mq_a, mq_b, mq_c;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(4), .INIT_VAL(32'd0), .SATURATE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(q_a), .qn(qn_a), .tc(tc_a), .changed(changed_a));

  jk_reg_bank #(.WIDTH(4), .INIT_VAL(32'd5), .SATURATE(1'b1)) dut_b (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(q_b), .qn(qn_b), .tc(tc_b), .changed(changed_b));

  jk_reg_bank #(.WIDTH(1), .INIT_VAL(32'd1), .SATURATE(1'b0)) dut_c (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j[0]), .k(k[0]), .d(d[0]),
    .q(q_c), .qn(qn_c), .tc(tc_c), .changed(changed_c));

  // Behavioural reference: returns {changed, tc, next_q}.
  function automatic logic [5:0] model(input logic [3:0] cq, input logic [1:0] m, input logic e,
                                       input logic [3:0] jj, input logic [3:0] kk,
                                       input logic [3:0] dd, input int w, input bit sat);
    logic [3:0] mask, nq;
    logic       t;
    mask = (w == 4) ? 4'hF : 4'h1;
    nq   = cq;
    t    = 1'b0;
    if (e) begin
      case (m)
        M_JK: for (int i = 0; i < w; i++) begin
          case ({jj[i], kk[i]})
            2'b10:   nq[i] = 1'b1;
            2'b01:   nq[i] = 1'b0;
            2'b11:   nq[i] = ~cq[i];
            default: nq[i] = cq[i];
          endcase
        end
        M_LD: nq = dd & mask;
        M_UP: if (cq == mask) begin t = 1'b1; nq = sat ? cq : 4'h0; end
              else nq = cq + 4'd1;
        default: if (cq == 4'h0) begin t = 1'b1; nq = sat ? cq : mask; end
                 else nq = cq - 4'd1;
      endcase
    end
    return {e && (nq != cq), t, nq};
  endfunction

  task automatic step(input logic [1:0] m, input logic e, input logic [3:0] jj,
                      input logic [3:0] kk, input logic [3:0] dd);
    logic [5:0] r;
    @(negedge clk);
    reset = 1'b0; mode = m; en = e; j = jj; k = kk; d = dd;
    r = model(mq_a, m, e, jj, kk, dd, 4, 1'b0);
    sb.push_back('{inst: 0, q: r[3:0], tc: r[4], ch: r[5]}); mq_a = r[3:0];
    r = model(mq_b, m, e, jj, kk, dd, 4, 1'b1);
    sb.push_back('{inst: 1, q: r[3:0], tc: r[4], ch: r[5]}); mq_b = r[3:0];
    r = model(mq_c, m, e, jj, kk, dd, 1, 1'b0);
    sb.push_back('{inst: 2, q: r[3:0], tc: r[4], ch: r[5]}); mq_c = r[3:0];
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq_a = 4'h0; mq_b = 4'h5; mq_c = 4'h1;
  endtask

  sb_t        ent;
  logic [3:0] aq, aqn, eqn;
  logic       atc, ach;

  always @(posedge clk) begin
    #1;
    while (sb.size() > 0) begin
      ent = sb.pop_front();
      case (ent.inst)
        0:       begin aq = q_a; aqn = qn_a; atc = tc_a; ach = changed_a; end
        1:       begin aq = q_b; aqn = qn_b; atc = tc_b; ach = changed_b; end
        default: begin aq = {3'b000, q_c}; aqn = {3'b000, qn_c}; atc = tc_c; ach = changed_c; end
      endcase
      eqn = (ent.inst == 2) ? {3'b000, ~ent.q[0]} : ~ent.q;
      checks++;
      if (aq !== ent.q) begin
        errors++; $display("FAIL sb_q inst%0d: got %h expected %h", ent.inst, aq, ent.q);
      end
      checks++;
      if (aqn !== eqn) begin
        errors++; $display("FAIL sb_qn inst%0d: got %h expected %h", ent.inst, aqn, eqn);
      end
      checks++;
      if (atc !== ent.tc) begin
        errors++; $display("FAIL sb_tc inst%0d: got %b expected %b", ent.inst, atc, ent.tc);
      end
      checks++;
      if (ach !== ent.ch) begin
        errors++; $display("FAIL sb_changed inst%0d: got %b expected %b", ent.inst, ach, ent.ch);
      end
    end
  end

  task automatic test_reset();
    checks++;
    if ({q_a, q_b, q_c} !== {4'h0, 4'h5, 1'b1}) begin
      errors++; $display("FAIL reset_q: got %h/%h/%b expected 0/5/1", q_a, q_b, q_c);
    end
    checks++;
    if ({tc_a, tc_b, tc_c, changed_a, changed_b, changed_c} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000",
                         {tc_a, tc_b, tc_c, changed_a, changed_b, changed_c});
    end
  endtask

  task automatic test_reset_jk();
    step(M_LD, 1'b1, 4'h0, 4'h0, 4'hA);
    checks++;
    if (q_a !== 4'hA) begin errors++; $display("FAIL load_a: got %h expected a", q_a); end
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({q_a, qn_a, tc_a, changed_a} !== {4'h0, 4'hF, 2'b00}) begin
      errors++; $display("FAIL async_reset: got q=%h qn=%h tc=%b ch=%b expected 0 f 0 0",
                         q_a, qn_a, tc_a, changed_a);
    end
    step(M_LD, 1'b1, 4'h0, 4'h0, 4'b0110);
    step(M_JK, 1'b1, 4'b0011, 4'b0101, 4'h0);
    checks++;
    if ({q_a, changed_a} !== {4'b0011, 1'b1}) begin
      errors++; $display("FAIL jk_modes: got q=%b ch=%b expected 0011 1", q_a, changed_a);
    end
    step(M_JK, 1'b1, 4'h0, 4'h0, 4'hF);
  endtask

  task automatic test_load_hold();
    step(M_LD, 1'b1, 4'h0, 4'h0, 4'h9);
    for (int i = 0; i < 3; i++) begin
      step(M_LD, 1'b0, 4'hF, 4'hF, 4'h3);
      checks++;
      if ({q_a, changed_a} !== {4'h9, 1'b0}) begin
        errors++; $display("FAIL en_hold[%0d]: got q=%h ch=%b expected 9 0", i, q_a, changed_a);
      end
    end
  endtask

  task automatic test_up_wrap();
    logic [3:0] eq [3];
    logic       et [3];
    eq = '{4'hF, 4'h0, 4'h1};
    et = '{1'b0, 1'b1, 1'b0};
    step(M_LD, 1'b1, 4'h0, 4'h0, 4'hE);
    for (int i = 0; i < 3; i++) begin
      step(M_UP, 1'b1, 4'h0, 4'h0, 4'h0);
      checks++;
      if ({q_a, tc_a} !== {eq[i], et[i]}) begin
        errors++; $display("FAIL up_wrap[%0d]: got q=%h tc=%b expected %h %b", i, q_a, tc_a, eq[i], et[i]);
      end
    end
  endtask

  task automatic test_down_wrap();
    logic [3:0] eq [3];
    logic       et [3];
    eq = '{4'h0, 4'hF, 4'hE};
    et = '{1'b0, 1'b1, 1'b0};
    step(M_LD, 1'b1, 4'h0, 4'h0, 4'h1);
    for (int i = 0; i < 3; i++) begin
      step(M_DN, 1'b1, 4'h0, 4'h0, 4'h0);
      checks++;
      if ({q_a, tc_a} !== {eq[i], et[i]}) begin
        errors++; $display("FAIL down_wrap[%0d]: got q=%h tc=%b expected %h %b", i, q_a, tc_a, eq[i], et[i]);
      end
    end
  endtask

  task automatic test_saturation();
    step(M_LD, 1'b1, 4'h0, 4'h0, 4'hE);
    for (int i = 0; i < 4; i++) begin
      step(M_UP, 1'b1, 4'h0, 4'h0, 4'h0);
      checks++;
      if ({q_b, tc_b, changed_b} !== {4'hF, (i != 0), (i == 0)}) begin
        errors++; $display("FAIL sat_up[%0d]: got q=%h tc=%b ch=%b expected f %b %b",
                           i, q_b, tc_b, changed_b, (i != 0), (i == 0));
      end
    end
    step(M_DN, 1'b1, 4'h0, 4'h0, 4'h0);
    checks++;
    if ({q_b, tc_b} !== {4'hE, 1'b0}) begin
      errors++; $display("FAIL sat_down: got q=%h tc=%b expected e 0", q_b, tc_b);
    end
  endtask

  task automatic test_reset_during_count();
    step(M_LD, 1'b1, 4'h0, 4'h0, 4'h6);
    step(M_UP, 1'b1, 4'h0, 4'h0, 4'h0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({q_b, qn_b} !== {4'h5, 4'hA}) begin
      errors++; $display("FAIL count_reset: got q=%h qn=%h expected 5 a", q_b, qn_b);
    end
    step(M_UP, 1'b1, 4'h0, 4'h0, 4'h0);
    checks++;
    if (q_b !== 4'h6) begin errors++; $display("FAIL count_resume: got %h expected 6", q_b); end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = M_JK; j = 4'h0; k = 4'h0; d = 4'h0;
    model_reset();
    #2;
    test_reset();
    test_reset_jk();
    test_load_hold();
    test_up_wrap();
    test_down_wrap();
    test_saturation();
    test_reset_during_count();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
